mnist_batch_sequencer: RTL and testbench
========================================

MNIST_BATCH_SEQUENCER -- requirements
Module: mnist_batch_sequencer

Interface
REQ-001 Parameter NUM_IMG, default 10: number of images per batch, legal range 1..256.
REQ-002 Parameter TIMEOUT, default 5000: maximum cycles to wait for acc_done per image.
REQ-003 Parameter IDX_W, default 8: width of img_idx; must satisfy 2^IDX_W >= NUM_IMG.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-low reset.
REQ-006 Port go, input, 1: single-cycle request to run one batch.
REQ-007 Port busy, output, 1: high from batch acceptance until batch_done.
REQ-008 Port batch_done, output, 1: one-cycle pulse when the batch ends.
REQ-009 Port img_idx, output, IDX_W: image/label select, driven to the image and label stores.
REQ-010 Port acc_start, output, 1: one-cycle start pulse to the accelerator.
REQ-011 Port acc_done, input, 1: accelerator completion, level; may stay high for several cycles.
REQ-012 Port acc_digit, input, 4: accelerator argmax; valid while acc_done is high.
REQ-013 Port exp_label, input, 4: expected label for img_idx; valid one cycle after img_idx changes.
REQ-014 Port pass_cnt, output, IDX_W+1: number of correct predictions.
REQ-015 Port fail_cnt, output, IDX_W+1: number of wrong predictions plus timeouts.
REQ-016 Port last_digit, output, 4: most recently captured acc_digit.
REQ-017 Port timeout_err, output, 1: sticky flag for the current batch; set on any timeout.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, SCORE, DRAIN and FINISH.
REQ-019 IDLE with go=1: clear img_idx, pass_cnt, fail_cnt and timeout_err; set busy; go to ISSUE next cycle.
REQ-020 go SHALL be ignored while busy=1.
REQ-021 ISSUE: assert acc_start for exactly one cycle; clear the watchdog; go to WAIT.
REQ-022 WAIT with acc_done=1: capture acc_digit into last_digit; go to SCORE.
REQ-023 WAIT: when the watchdog reaches TIMEOUT cycles with acc_done=0, increment fail_cnt, set timeout_err, and go to DRAIN.
REQ-024 If acc_done=1 in the same cycle the watchdog expires, acc_done SHALL win and no timeout is recorded.
REQ-025 SCORE (1 cycle): if last_digit == exp_label, increment pass_cnt; otherwise increment fail_cnt. Values above 9 always count as fail.
REQ-026 DRAIN: hold until acc_done=0. Then, if img_idx == NUM_IMG-1, go to FINISH; otherwise increment img_idx and go to ISSUE.
REQ-027 After a timeout, DRAIN sees acc_done=0 and SHALL exit on its first cycle.
REQ-028 FINISH: pulse batch_done for one cycle, clear busy, go to IDLE; the counters hold until the next accepted go.
REQ-029 Minimum per-image overhead SHALL be 4 cycles beyond accelerator latency (ISSUE, WAIT-exit, SCORE, DRAIN); minimum go-to-first-acc_start latency is 1 cycle.
REQ-030 pass_cnt + fail_cnt SHALL equal NUM_IMG at batch_done.
REQ-031 img_idx SHALL never exceed NUM_IMG-1.

Reset
REQ-032 On rst=0 at a clock edge, the state SHALL become IDLE, and busy, batch_done, acc_start, timeout_err, img_idx, pass_cnt, fail_cnt, last_digit and the watchdog SHALL all become 0.
REQ-033 Reset mid-batch SHALL abort with no batch_done pulse; a later go starts a fresh batch from image 0.

Configuration
REQ-034 With MNIST_SEQ_FAILMAP_EN defined, add output fail_map [NUM_IMG-1:0]: bit i is set when image i fails or times out, cleared on accepted go and on reset.
REQ-035 Without MNIST_SEQ_FAILMAP_EN, the fail_map port and its storage SHALL not exist; all other behaviour is identical.

Structure
REQ-036 Package mnist_seq_pkg SHALL hold the FSM state encoding, DIGIT_W=4 and MAX_DIGIT=9.
REQ-037 The watchdog counter SHALL be sub-module mnist_seq_watchdog (inputs clear and enable, parameter TIMEOUT, output expired).

Verification
REQ-038 NUM_IMG=3, model returns matching digits after 20 cycles each: pass_cnt=3, fail_cnt=0, batch_done once, timeout_err=0.
REQ-039 Image 1 returns digit 7 with label 2: fail_cnt=1, pass_cnt=2, last_digit=7; with the macro, fail_map=3'b010.
REQ-040 TIMEOUT=50, model never asserts done for image 0: timeout_err=1 after 50 WAIT cycles, fail_cnt=1, batch continues to image 1.
REQ-041 acc_done held high for 5 cycles: exactly one acc_start per image and no double scoring.
REQ-042 go pulsed while busy, then rst=0 during image 1: go ignored; all outputs 0 next cycle, no batch_done; fresh go restarts at img_idx=0.
REQ-043 acc_done rises in the same cycle the watchdog expires: result is scored normally and timeout_err stays 0.

Source files
------------

// File: rtl/mnist_seq_pkg.sv
// ---------------------------------------------------------------------------
// mnist_seq_pkg
// Shared definitions for the MNIST batch sequencer. It holds the FSM state
// encoding, the width of an accelerator digit, the largest legal digit value,
// and the rule that decides whether a prediction is correct.
// ---------------------------------------------------------------------------
package mnist_seq_pkg;

   localparam int DIGIT_W   = 4;
   localparam int MAX_DIGIT = 9;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      SCORE  = 3'd3,
      DRAIN  = 3'd4,
      FINISH = 3'd5
   } seq_state_t;

   // A prediction is correct only if it equals the label and is a real digit.
   // The 4-bit encoding can carry 10..15, and those values always count as
   // wrong, even when the label store holds the same out-of-range value.
   function automatic logic digit_matches(input logic [DIGIT_W-1:0] digit,
                                          input logic [DIGIT_W-1:0] label);
      return (digit == label) && (digit <= DIGIT_W'(MAX_DIGIT));
   endfunction

endpackage

// File: rtl/mnist_seq_watchdog.sv
// ---------------------------------------------------------------------------
// mnist_seq_watchdog
// Counts the cycles spent waiting for the accelerator on one image.
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset
//   clear   : restart the count from zero (wins over enable)
//   enable  : count this cycle
//   expired : high during the TIMEOUT-th consecutive enabled cycle
// ---------------------------------------------------------------------------
module mnist_seq_watchdog #(
   parameter int TIMEOUT = 5000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   // The count is k-1 during the k-th enabled cycle. Flagging expiry
   // combinationally in that cycle lets the sequencer leave WAIT after exactly
   // TIMEOUT cycles, and lets a same-cycle acc_done take priority.
   assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         // Saturates at TIMEOUT-1 so the count cannot wrap around.
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mnist_batch_sequencer.sv
// ---------------------------------------------------------------------------
// mnist_batch_sequencer
// Runs a batch of NUM_IMG images through an accelerator and scores each
// prediction against the expected label.
//
// Optional feature: define MNIST_SEQ_FAILMAP_EN to add the fail_map output,
// which holds one bit per image that failed or timed out.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-low reset
//   go          : one-cycle batch request; ignored while busy
//   busy        : high while a batch is in progress
//   batch_done  : one-cycle pulse at the end of a batch
//   img_idx     : image/label select for the image and label stores
//   acc_start   : one-cycle accelerator start pulse
//   acc_done    : accelerator completion (level)
//   acc_digit   : accelerator argmax; valid while acc_done is high
//   exp_label   : expected label; valid one cycle after img_idx changes
//   pass_cnt    : number of correct predictions in this batch
//   fail_cnt    : number of wrong predictions plus timeouts in this batch
//   last_digit  : most recently captured acc_digit
//   timeout_err : sticky for the batch; set on any timeout
//   fail_map    : (MNIST_SEQ_FAILMAP_EN only) bit i is set when image i fails
// ---------------------------------------------------------------------------
module mnist_batch_sequencer
   import mnist_seq_pkg::*;
#(
   parameter int NUM_IMG = 10,
   parameter int TIMEOUT = 5000,
   parameter int IDX_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   output logic               busy,
   output logic               batch_done,
   output logic [IDX_W-1:0]   img_idx,
   output logic               acc_start,
   input  logic               acc_done,
   input  logic [3:0]         acc_digit,
   input  logic [3:0]         exp_label,
   output logic [IDX_W:0]     pass_cnt,
   output logic [IDX_W:0]     fail_cnt,
   output logic [3:0]         last_digit,
   output logic               timeout_err
`ifdef MNIST_SEQ_FAILMAP_EN
   ,
   output logic [NUM_IMG-1:0] fail_map
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMG - 1);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

   seq_state_t state;
   seq_state_t state_next;

   logic wd_clear;
   logic wd_enable;
   logic wd_expired;
   logic last_image;

   assign last_image = (img_idx == LAST_IDX);

   // ------------------------------------------------------------------------
   // Watchdog: restarted in ISSUE and counting only while in WAIT.
   // ------------------------------------------------------------------------
   mnist_seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and control outputs
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case statement, so no
      // path leaves a value unassigned and no latch is inferred.
      state_next = state;
      busy       = (state != IDLE);
      acc_start  = 1'b0;
      batch_done = 1'b0;
      wd_clear   = 1'b0;
      wd_enable  = 1'b0;

      unique case (state)
         IDLE: begin
            if (go) begin
               state_next = ISSUE;
            end
         end

         ISSUE: begin
            acc_start  = 1'b1;
            wd_clear   = 1'b1;
            state_next = WAIT;
         end

         WAIT: begin
            wd_enable = 1'b1;
            // A completion in the expiry cycle is still a completion.
            if (acc_done) begin
               state_next = SCORE;
            end else if (wd_expired) begin
               state_next = DRAIN;
            end
         end

         SCORE: begin
            state_next = DRAIN;
         end

         DRAIN: begin
            // Wait for the level acc_done to drop so that one completion is
            // never scored twice.
            if (!acc_done) begin
               state_next = last_image ? FINISH : ISSUE;
            end
         end

         FINISH: begin
            batch_done = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Batch datapath: image index, scoreboard counters and captured digit.
   // The counters stay at their final values after FINISH and are cleared
   // only when the next batch is accepted.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         img_idx     <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         last_digit  <= '0;
         timeout_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  img_idx     <= '0;
                  pass_cnt    <= '0;
                  fail_cnt    <= '0;
                  timeout_err <= 1'b0;
               end
            end

            WAIT: begin
               if (acc_done) begin
                  last_digit <= acc_digit;
               end else if (wd_expired) begin
                  fail_cnt    <= fail_cnt + CNT_ONE;
                  timeout_err <= 1'b1;
               end
            end

            SCORE: begin
               if (digit_matches(last_digit, exp_label)) begin
                  pass_cnt <= pass_cnt + CNT_ONE;
               end else begin
                  fail_cnt <= fail_cnt + CNT_ONE;
               end
            end

            DRAIN: begin
               // The index stops at the last image, so it never runs past
               // the end of the batch.
               if (!acc_done && !last_image) begin
                  img_idx <= img_idx + IDX_W'(1);
               end
            end

            default: begin
            end
         endcase
      end
   end

`ifdef MNIST_SEQ_FAILMAP_EN
   // ------------------------------------------------------------------------
   // Per-image failure map. A shifted one-hot mask avoids indexing the map
   // with the (possibly wider) image index.
   // ------------------------------------------------------------------------
   logic [NUM_IMG-1:0] idx_mask;

   assign idx_mask = NUM_IMG'(1) << img_idx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fail_map <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  fail_map <= '0;
               end
            end

            WAIT: begin
               if (!acc_done && wd_expired) begin
                  fail_map <= fail_map | idx_mask;
               end
            end

            SCORE: begin
               if (!digit_matches(last_digit, exp_label)) begin
                  fail_map <= fail_map | idx_mask;
               end
            end

            default: begin
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_mnist_batch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mnist_batch_sequencer
// Directed bench for mnist_batch_sequencer with NUM_IMG=3, TIMEOUT=50.
// An accelerator model answers each acc_start after a programmable latency,
// and a label-store model returns the label for img_idx one cycle late.
// Expected batch results are queued when a batch is started and compared
// when batch_done pulses.
// ---------------------------------------------------------------------------
module tb_mnist_batch_sequencer;

   localparam int NUM_IMG = 3;
   localparam int TIMEOUT = 50;
   localparam int IDX_W   = 2;

   typedef struct {
      int         pass_n;
      int         fail_n;
      logic       tmo;
      logic [3:0] last;
      logic [2:0] fmap;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               go;
   logic               busy;
   logic               batch_done;
   logic [IDX_W-1:0]   img_idx;
   logic               acc_start;
   logic               acc_done;
   logic [3:0]         acc_digit;
   logic [3:0]         exp_label;
   logic [IDX_W:0]     pass_cnt;
   logic [IDX_W:0]     fail_cnt;
   logic [3:0]         last_digit;
   logic               timeout_err;
`ifdef MNIST_SEQ_FAILMAP_EN
   logic [NUM_IMG-1:0] fail_map;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   exp_t sb[$];

   // Model configuration, written by the main sequence between batches.
   logic [3:0] digit_mem [NUM_IMG];
   logic [3:0] label_mem [NUM_IMG];
   int         lat_mem   [NUM_IMG];
   bit         never_mem [NUM_IMG];
   int         hold_cycles = 1;

   int start_cnt = 0;
   int done_cnt  = 0;

   mnist_batch_sequencer #(
      .NUM_IMG (NUM_IMG),
      .TIMEOUT (TIMEOUT),
      .IDX_W   (IDX_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .busy        (busy),
      .batch_done  (batch_done),
      .img_idx     (img_idx),
      .acc_start   (acc_start),
      .acc_done    (acc_done),
      .acc_digit   (acc_digit),
      .exp_label   (exp_label),
      .pass_cnt    (pass_cnt),
      .fail_cnt    (fail_cnt),
      .last_digit  (last_digit),
      .timeout_err (timeout_err)
`ifdef MNIST_SEQ_FAILMAP_EN
      ,
      .fail_map    (fail_map)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1, "global timeout");
   end

   // ---------------------------------------------------------------------
   // Label store: exp_label follows img_idx with one cycle of latency.
   // ---------------------------------------------------------------------
   initial begin
      int idx_d;
      idx_d     = 0;
      exp_label = '0;
      forever begin
         @(negedge clk);
         exp_label = label_mem[idx_d];
         if (!$isunknown(img_idx) && int'(img_idx) < NUM_IMG) idx_d = int'(img_idx);
      end
   end

   // ---------------------------------------------------------------------
   // Accelerator: after acc_start, wait lat_mem cycles, then hold acc_done
   // high for hold_cycles cycles. never_mem suppresses the answer.
   // ---------------------------------------------------------------------
   initial begin
      int i;
      acc_done  = 1'b0;
      acc_digit = '0;
      forever begin
         @(negedge clk);
         if (acc_start === 1'b1) begin
            start_cnt++;
            i = int'(img_idx);
            if (i < NUM_IMG && !never_mem[i]) begin
               repeat (lat_mem[i]) @(negedge clk);
               acc_digit = digit_mem[i];
               acc_done  = 1'b1;
               repeat (hold_cycles) @(negedge clk);
               acc_done  = 1'b0;
               acc_digit = '0;
            end
         end
      end
   end

   // batch_done pulse counter
   initial begin
      forever begin
         @(negedge clk);
         if (batch_done === 1'b1) done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_image(input int i, input logic [3:0] d, input logic [3:0] l,
                            input int lat, input bit never);
      digit_mem[i] = d;
      label_mem[i] = l;
      lat_mem[i]   = lat;
      never_mem[i] = never;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"},        32'(busy),        0);
      check({tag, "_batch_done"},  32'(batch_done),  0);
      check({tag, "_acc_start"},   32'(acc_start),   0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 0);
      check({tag, "_img_idx"},     32'(img_idx),     0);
      check({tag, "_pass_cnt"},    32'(pass_cnt),    0);
      check({tag, "_fail_cnt"},    32'(fail_cnt),    0);
      check({tag, "_last_digit"},  32'(last_digit),  0);
`ifdef MNIST_SEQ_FAILMAP_EN
      check({tag, "_fail_map"},    32'(fail_map),    0);
`endif
   endtask

   // Queue the expected result, pulse go, and check the ISSUE cycle that
   // must follow one cycle later. Returns on the negedge of that cycle.
   task automatic start_batch(input string tag, input int p, input int f,
                              input logic tmo, input logic [3:0] last,
                              input logic [2:0] fmap);
      exp_t e;
      e.pass_n = p;
      e.fail_n = f;
      e.tmo    = tmo;
      e.last   = last;
      e.fmap   = fmap;
      sb.push_back(e);
      start_cnt = 0;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check({tag, "_first_acc_start"}, 32'(acc_start),   1);
      check({tag, "_busy_on_accept"},  32'(busy),        1);
      check({tag, "_idx_cleared"},     32'(img_idx),     0);
      check({tag, "_pass_cleared"},    32'(pass_cnt),    0);
      check({tag, "_fail_cleared"},    32'(fail_cnt),    0);
      check({tag, "_tmo_cleared"},     32'(timeout_err), 0);
   endtask

   task automatic finish_batch(input string tag);
      exp_t e;
      bit   found;
      int   done_before;
      found       = 1'b0;
      done_before = done_cnt;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(negedge clk);
         if (batch_done === 1'b1) found = 1'b1;
      end
      check({tag, "_batch_done_seen"}, 32'(found), 1);
      e = sb.pop_front();
      if (found) begin
         check({tag, "_pass_cnt"},    32'(pass_cnt),    32'(e.pass_n));
         check({tag, "_fail_cnt"},    32'(fail_cnt),    32'(e.fail_n));
         check({tag, "_total"},       32'(pass_cnt) + 32'(fail_cnt), NUM_IMG);
         check({tag, "_timeout_err"}, 32'(timeout_err), 32'(e.tmo));
         check({tag, "_last_digit"},  32'(last_digit),  32'(e.last));
         check({tag, "_acc_starts"},  32'(start_cnt),   NUM_IMG);
`ifdef MNIST_SEQ_FAILMAP_EN
         check({tag, "_fail_map"},    32'(fail_map),    32'(e.fmap));
`endif
         @(negedge clk);
         check({tag, "_done_pulse_1cyc"}, 32'(batch_done), 0);
         check({tag, "_busy_after"},      32'(busy),       0);
         check({tag, "_done_count"},      32'(done_cnt),   32'(done_before + 1));
         check({tag, "_pass_holds"},      32'(pass_cnt),   32'(e.pass_n));
      end
   endtask

   initial begin
      bit   seen;
      int   done_before;
      rst = 1'b0;
      go  = 1'b0;
      for (int i = 0; i < NUM_IMG; i++) set_image(i, 4'd0, 4'd0, 20, 1'b0);

      // Reset state
      repeat (3) @(negedge clk);
      check_cleared("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // All images correct, 20-cycle accelerator
      set_image(0, 4'd3, 4'd3, 20, 1'b0);
      set_image(1, 4'd5, 4'd5, 20, 1'b0);
      set_image(2, 4'd8, 4'd8, 20, 1'b0);
      start_batch("all_pass", 3, 0, 1'b0, 4'd8, 3'b000);
      finish_batch("all_pass");

      // Image 1 predicts 7 against label 2
      set_image(0, 4'd3, 4'd3, 20, 1'b0);
      set_image(1, 4'd7, 4'd2, 20, 1'b0);
      set_image(2, 4'd7, 4'd7, 20, 1'b0);
      start_batch("mispredict", 2, 1, 1'b0, 4'd7, 3'b010);
      finish_batch("mispredict");

      // Out-of-range digits fail even when equal to the label
      set_image(0, 4'd10, 4'd10, 15, 1'b0);
      set_image(1, 4'd9,  4'd9,  15, 1'b0);
      set_image(2, 4'd15, 4'd15, 15, 1'b0);
      start_batch("above_nine", 1, 2, 1'b0, 4'd15, 3'b101);
      finish_batch("above_nine");

      // Image 0 never completes: timeout after exactly 50 WAIT cycles
      set_image(0, 4'd1, 4'd1, 20, 1'b1);
      set_image(1, 4'd4, 4'd4, 20, 1'b0);
      set_image(2, 4'd6, 4'd6, 20, 1'b0);
      start_batch("timeout", 2, 1, 1'b1, 4'd6, 3'b001);
      repeat (TIMEOUT) @(negedge clk);
      check("timeout_not_early_err", 32'(timeout_err), 0);
      check("timeout_not_early_fail", 32'(fail_cnt), 0);
      @(negedge clk);
      check("timeout_err_set", 32'(timeout_err), 1);
      check("timeout_fail_cnt", 32'(fail_cnt), 1);
      @(negedge clk);
      check("timeout_drain_exit_start", 32'(acc_start), 1);
      check("timeout_next_image", 32'(img_idx), 1);
      finish_batch("timeout");

      // acc_done rises in the very cycle the watchdog expires
      set_image(0, 4'd2, 4'd2, TIMEOUT, 1'b0);
      set_image(1, 4'd0, 4'd0, 20, 1'b0);
      set_image(2, 4'd9, 4'd9, 20, 1'b0);
      start_batch("race", 3, 0, 1'b0, 4'd9, 3'b000);
      repeat (TIMEOUT + 1) @(negedge clk);
      check("race_no_timeout", 32'(timeout_err), 0);
      check("race_captured", 32'(last_digit), 2);
      @(negedge clk);
      check("race_scored", 32'(pass_cnt), 1);
      check("race_no_fail", 32'(fail_cnt), 0);
      finish_batch("race");

      // acc_done held high for 5 cycles: one start, one score per image
      hold_cycles = 5;
      set_image(0, 4'd1, 4'd1, 10, 1'b0);
      set_image(1, 4'd2, 4'd3, 10, 1'b0);
      set_image(2, 4'd5, 4'd5, 10, 1'b0);
      start_batch("long_done", 2, 1, 1'b0, 4'd5, 3'b010);
      finish_batch("long_done");
      hold_cycles = 1;

      // go while busy is ignored, then reset during image 1 aborts the batch
      for (int i = 0; i < NUM_IMG; i++) set_image(i, 4'(i + 1), 4'(i + 1), 20, 1'b0);
      start_batch("abort", 3, 0, 1'b0, 4'd3, 3'b000);
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
         @(negedge clk);
         if (img_idx === 2'd1) seen = 1'b1;
      end
      check("abort_reached_image1", 32'(seen), 1);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("busy_go_ignored_idx", 32'(img_idx), 1);
      check("busy_go_ignored_pass", 32'(pass_cnt), 1);
      rst = 1'b0;
      @(negedge clk);
      check_cleared("midreset");
      rst = 1'b1;
      void'(sb.pop_back());
      done_before = done_cnt;
      repeat (40) @(negedge clk);
      check("abort_no_batch_done", 32'(done_cnt), 32'(done_before));
      check("abort_idle", 32'(busy), 0);

      // Fresh batch after the abort starts again at image 0
      start_batch("restart", 3, 0, 1'b0, 4'd3, 3'b000);
      finish_batch("restart");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
